lif_neuron_array: RTL and testbench

Parametrised successor to the single leaky integrate-and-fire neuron top. It holds N independent LIF neurons that update in parallel. The neurons share runtime configuration: threshold, leak shift, refractory length and reset mode. The block outputs per-neuron spikes and refractory flags, plus a selectable membrane-state readout for the pad-limited top level.

---
 rtl/lif_pkg.sv | 33 +++
 rtl/lif_neuron_cell.sv | 86 ++++++++
 rtl/lif_neuron_array.sv | 76 +++++++
 tb/tb_lif_neuron_array.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array.
//   lif_state_e : per-channel state (integrating or refractory)
//   RST_ZERO / RST_SUB : values of the reset-mode configuration bit
//   sel_width() : width of the channel-select port (at least 1 bit)
//   sat_add()   : unsigned add clamped to 2^width-1
package lif_pkg;

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } lif_state_e;

  localparam logic RST_ZERO = 1'b0;
  localparam logic RST_SUB  = 1'b1;

  // A single channel still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The sum is formed one bit wider than the operands so the carry is seen
  // before clamping; callers keep only the low 'width' bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_cell.sv
// One leaky integrate-and-fire neuron.
//   clk, rst       : clock, synchronous active-high reset
//   en             : update strobe; state holds and spike drops when low
//   cur            : input current for this channel
//   thresh         : firing threshold (0 disables firing)
//   leak_shift     : leak = v >> leak_shift (0 means no leak)
//   refrac         : refractory length loaded on a spike
//   reset_mode     : RST_ZERO clears v on spike, RST_SUB subtracts thresh
//   v              : membrane value
//   spike          : registered one-cycle spike pulse
//   st             : FSM state, high-level view of the refractory counter
module lif_neuron_cell
  import lif_pkg::*;
#(
  parameter int W        = 8,
  parameter int REFRAC_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [W-1:0]        cur,
  input  logic [W-1:0]        thresh,
  input  logic [2:0]          leak_shift,
  input  logic [REFRAC_W-1:0] refrac,
  input  logic                reset_mode,
  output logic [W-1:0]        v,
  output logic                spike,
  output lif_state_e          st
);

  lif_state_e          st_next;
  logic [REFRAC_W-1:0] cnt, cnt_next;
  logic [W-1:0]        v_next, leak, v_leaked, s;
  logic                spike_next, fire;

  // leak never exceeds v, so v_leaked cannot wrap.
  always_comb begin
    leak     = (leak_shift == 3'd0) ? '0 : (v >> leak_shift);
    v_leaked = v - leak;
    s        = W'(sat_add(32'(v_leaked), 32'(cur), W));
    fire     = (thresh != '0) && (s >= thresh);
  end

  always_comb begin
    st_next    = st;
    v_next     = v;
    cnt_next   = cnt;
    spike_next = 1'b0;
    if (en) begin
      case (st)
        ST_INTEGRATE: begin
          if (fire) begin
            spike_next = 1'b1;
            v_next     = (reset_mode == RST_SUB) ? (s - thresh) : '0;
            cnt_next   = refrac;
            st_next    = (refrac != '0) ? ST_REFRACTORY : ST_INTEGRATE;
          end else begin
            v_next = s;
          end
        end
        ST_REFRACTORY: begin
          // Input current is ignored; only the leak acts on v.
          v_next   = v_leaked;
          cnt_next = cnt - REFRAC_W'(1);
          st_next  = (cnt == REFRAC_W'(1)) ? ST_INTEGRATE : ST_REFRACTORY;
        end
        default: st_next = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_INTEGRATE;
      v     <= '0;
      cnt   <= '0;
      spike <= 1'b0;
    end else begin
      st    <= st_next;
      v     <= v_next;
      cnt   <= cnt_next;
      spike <= spike_next;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_NEURONS independent LIF neurons sharing one configuration.
//   clk, rst        : clock, synchronous active-high reset
//   en              : update strobe for every channel
//   cur_i           : per-channel current, channel k at [k*W +: W]
//   cfg_thresh      : firing threshold (0 disables firing)
//   cfg_leak_shift  : leak shift (0 means no leak)
//   cfg_refrac      : refractory cycles after a spike
//   cfg_reset_mode  : 0 clear v on spike, 1 subtract threshold
//   sel             : channel shown on state_o
//   state_o         : registered membrane value of channel sel
//   spike_o         : per-channel one-cycle spike pulses
//   refrac_o        : per-channel refractory flags
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter  int N_NEURONS = 4,
  parameter  int W         = 8,
  parameter  int REFRAC_W  = 4,
  localparam int SEL_W     = sel_width(N_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_NEURONS*W-1:0] cur_i,
  input  logic [W-1:0]           cfg_thresh,
  input  logic [2:0]             cfg_leak_shift,
  input  logic [REFRAC_W-1:0]    cfg_refrac,
  input  logic                   cfg_reset_mode,
  input  logic [SEL_W-1:0]       sel,
  output logic [W-1:0]           state_o,
  output logic [N_NEURONS-1:0]   spike_o,
  output logic [N_NEURONS-1:0]   refrac_o
);

  localparam int N_PAD = 1 << SEL_W;

  logic [N_NEURONS-1:0][W-1:0] v_all;
  lif_state_e                  st_all [N_NEURONS];
  logic [W-1:0]                v_pad  [N_PAD];

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_cell
    lif_neuron_cell #(
      .W        (W),
      .REFRAC_W (REFRAC_W)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .cur        (cur_i[k*W +: W]),
      .thresh     (cfg_thresh),
      .leak_shift (cfg_leak_shift),
      .refrac     (cfg_refrac),
      .reset_mode (cfg_reset_mode),
      .v          (v_all[k]),
      .spike      (spike_o[k]),
      .st         (st_all[k])
    );
    // The refractory state is exactly "counter non-zero".
    assign refrac_o[k] = (st_all[k] == ST_REFRACTORY);
  end

  // Select codes with no channel behind them read as zero.
  for (genvar k = 0; k < N_PAD; k++) begin : g_pad
    if (k < N_NEURONS) begin : g_real
      assign v_pad[k] = v_all[k];
    end else begin : g_zero
      assign v_pad[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     state_o <= '0;
    else if (en) state_o <= v_pad[sel];
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (N=4, W=8, REFRAC_W=4).
module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N*W-1:0] cur_i;
  logic [W-1:0]   cfg_thresh;
  logic [2:0]     cfg_leak_shift;
  logic [RW-1:0]  cfg_refrac;
  logic           cfg_reset_mode;
  logic [1:0]     sel;
  logic [W-1:0]   state_o;
  logic [N-1:0]   spike_o;
  logic [N-1:0]   refrac_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lif_neuron_array #(.N_NEURONS(N), .W(W), .REFRAC_W(RW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .cur_i          (cur_i),
    .cfg_thresh     (cfg_thresh),
    .cfg_leak_shift (cfg_leak_shift),
    .cfg_refrac     (cfg_refrac),
    .cfg_reset_mode (cfg_reset_mode),
    .sel            (sel),
    .state_o        (state_o),
    .spike_o        (spike_o),
    .refrac_o       (refrac_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [W-1:0] th, input logic [2:0] sh,
                         input logic [RW-1:0] rf, input logic md);
    cfg_thresh     = th;
    cfg_leak_shift = sh;
    cfg_refrac     = rf;
    cfg_reset_mode = md;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_cfg(8'd50, 3'd0, 4'd0, 1'b0);
    cur_i = {4{8'd77}};
    en    = 1'b1;
    sel   = 2'd0;
    rst   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (state_o !== 8'd0 || spike_o !== 4'd0 || refrac_o !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: state=%0d spike=%b refrac=%b, want 0/0000/0",
                 i, state_o, spike_o, refrac_o);
      end
    end
    rst = 1'b0;
    // Enter refractory, then reset in the middle of it.
    set_cfg(8'd100, 3'd0, 4'd3, 1'b0);
    cur_i = {8'd0, 8'd0, 8'd0, 8'd120};
    tick();
    n_checks++;
    if (spike_o !== 4'b0001 || refrac_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_pre_fire: spike=%b refrac=%b, want 0001/0001", spike_o, refrac_o);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (refrac_o !== 4'd0 || spike_o !== 4'd0 || state_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_refrac: refrac=%b spike=%b state=%0d, want 0000/0000/0",
               refrac_o, spike_o, state_o);
    end
    rst   = 1'b0;
    cur_i = {8'd0, 8'd0, 8'd0, 8'd50};
    tick();
    n_checks++;
    if (refrac_o !== 4'd0 || spike_o !== 4'd0 || state_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release: refrac=%b spike=%b state=%0d, want 0000/0000/0",
               refrac_o, spike_o, state_o);
    end
    tick();
    n_checks++;
    if (state_o !== 8'd50) begin
      n_fail++;
      $display("FAIL reset_v_cleared: state=%0d, want 50", state_o);
    end
  endtask

  task automatic test_integrate_fire();
    logic [W-1:0] v_exp  [8] = '{8'd30, 8'd60, 8'd90, 8'd0, 8'd30, 8'd60, 8'd90, 8'd0};
    logic         sp_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] st_exp;
    do_reset();
    set_cfg(8'd100, 3'd0, 4'd0, 1'b0);
    cur_i = {8'd0, 8'd0, 8'd0, 8'd30};
    sel   = 2'd0;
    en    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      st_exp = (k == 0) ? 8'd0 : v_exp[k-1];
      tick();
      n_checks++;
      if (spike_o !== {3'b000, sp_exp[k]} || state_o !== st_exp || refrac_o !== 4'd0) begin
        n_fail++;
        $display("FAIL integrate_edge%0d: spike=%b state=%0d refrac=%b, want %b/%0d/0000",
                 k + 1, spike_o, state_o, refrac_o, {3'b000, sp_exp[k]}, st_exp);
      end
    end
  endtask

  task automatic test_leak();
    logic [W-1:0] exp_v;
    do_reset();
    set_cfg(8'd255, 3'd1, 4'd0, 1'b0);
    sel   = 2'd0;
    en    = 1'b1;
    cur_i = {8'd0, 8'd0, 8'd0, 8'd200};
    tick();
    cur_i = '0;
    // v = v - (v >> 1): 200 100 50 25 13 7 4 2 1 1
    exp_q = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd13, 8'd7, 8'd4, 8'd2, 8'd1, 8'd1};
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (state_o !== exp_v || spike_o !== 4'd0) begin
        n_fail++;
        $display("FAIL leak_step%0d: state=%0d spike=%b, want %0d/0000", k, state_o, spike_o, exp_v);
      end
    end
  endtask

  task automatic test_saturate_subtract();
    do_reset();
    set_cfg(8'd250, 3'd0, 4'd0, 1'b1);
    sel   = 2'd0;
    en    = 1'b1;
    cur_i = {8'd0, 8'd0, 8'd0, 8'd255};
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (spike_o !== 4'b0001 || state_o !== ((k == 0) ? 8'd0 : 8'd5)) begin
        n_fail++;
        $display("FAIL saturate_edge%0d: spike=%b state=%0d, want 0001/%0d",
                 k + 1, spike_o, state_o, (k == 0) ? 0 : 5);
      end
    end
  endtask

  task automatic test_refractory();
    logic sp_exp [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic rf_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_cfg(8'd100, 3'd0, 4'd3, 1'b0);
    sel   = 2'd0;
    en    = 1'b1;
    cur_i = {8'd0, 8'd0, 8'd0, 8'd120};
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (spike_o !== {3'b000, sp_exp[k]} || refrac_o !== {3'b000, rf_exp[k]} ||
          state_o !== 8'd0) begin
        n_fail++;
        $display("FAIL refrac_edge%0d: spike=%b refrac=%b state=%0d, want %b/%b/0",
                 k + 1, spike_o, refrac_o, state_o, {3'b000, sp_exp[k]}, {3'b000, rf_exp[k]});
      end
    end
  endtask

  task automatic test_en_independence();
    logic         en_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]   sp_exp [4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [W-1:0] st_exp [4] = '{8'd0, 8'd0, 8'd50, 8'd50};
    logic [W-1:0] sw_exp [4] = '{8'd30, 8'd60, 8'd50, 8'd0};
    do_reset();
    set_cfg(8'd100, 3'd0, 4'd0, 1'b0);
    cur_i = {8'd0, 8'd50, 8'd20, 8'd10};
    sel   = 2'd2;
    for (int k = 0; k < 4; k++) begin
      en = en_seq[k];
      tick();
      n_checks++;
      if (spike_o !== sp_exp[k] || state_o !== st_exp[k]) begin
        n_fail++;
        $display("FAIL en_edge%0d: spike=%b state=%0d, want %b/%0d",
                 k + 1, spike_o, state_o, sp_exp[k], st_exp[k]);
      end
    end
    // v is now (20,40,0,0); add one more step with firing disabled.
    en         = 1'b1;
    cfg_thresh = 8'd0;
    tick();
    n_checks++;
    if (spike_o !== 4'd0) begin
      n_fail++;
      $display("FAIL thresh_zero: spike=%b, want 0000", spike_o);
    end
    cur_i = '0;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      n_checks++;
      if (state_o !== sw_exp[k]) begin
        n_fail++;
        $display("FAIL sel_sweep%0d: state=%0d, want %0d", k, state_o, sw_exp[k]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    cur_i = '0;
    sel   = '0;
    set_cfg(8'd0, 3'd0, 4'd0, 1'b0);
    test_reset();
    test_integrate_fire();
    test_leak();
    test_saturate_subtract();
    test_refractory();
    test_en_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
